pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/pipe_stage_stats.sv | 42 ++++
 rtl/pipe_stage.sv | 132 +++++++++++++
 tb/tb_pipe_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline stage: state encoding and an occupancy helper.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int unsigned OCC_W = 2;

    // Number of entries held in a given state.
    function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_t st);
        logic [OCC_W-1:0] occ;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Statistics counters for pipe_stage: stall cycles and flushes that discarded
// data. Both counters saturate at all-ones.
module pipe_stage_stats
    import cpu_types_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             out_valid,
    input  logic             out_ready,
    input  logic [OCC_W-1:0] occupancy,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        stall_evt_s;
    logic        flush_evt_s;

    assign stall_evt_s = out_valid & ~out_ready;
    assign flush_evt_s = flush & (occupancy != 2'd0);

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (flush_evt_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry (main + skid) valid/ready pipeline stage with registered in_ready.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     NOP_VALUE = '0
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    pipe_state_t      state_r;
    pipe_state_t      state_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [1:0]       occupancy_r;
    logic             accept_s;
    logic             consume_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // Next-state and entry updates; flush wins over every handshake and an
    // emptied main entry is parked at NOP_VALUE so out_data shows a bubble.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = EMPTY;
            main_s  = NOP_VALUE;
            skid_s  = NOP_VALUE;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_s = ONE;
                        main_s  = in_data;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && consume_s) begin
                        state_s = ONE;
                        main_s  = in_data;
                    end else if (accept_s) begin
                        state_s = FULL;
                        skid_s  = in_data;
                    end else if (consume_s) begin
                        state_s = EMPTY;
                        main_s  = NOP_VALUE;
                    end else begin
                        state_s = ONE;
                    end
                end
                FULL: begin
                    if (consume_s) begin
                        state_s = ONE;
                        main_s  = skid_r;
                        skid_s  = NOP_VALUE;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s = EMPTY;
                    main_s  = NOP_VALUE;
                    skid_s  = NOP_VALUE;
                end
            endcase
        end
    end

    // State, payload and flag registers; flags are precomputed from the next
    // state so in_ready has no combinational path from out_ready/in_valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= EMPTY;
            main_r      <= NOP_VALUE;
            skid_r      <= NOP_VALUE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            main_r      <= main_s;
            skid_r      <= skid_s;
            in_ready_r  <= (state_s != FULL);
            out_valid_r <= (state_s != EMPTY);
            occupancy_r <= state_occupancy(state_s);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occupancy_r;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clk       (CLK),
        .rst       (RST),
        .flush     (flush),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .occupancy (occupancy_r),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios followed by random
// valid/ready traffic, checked against a queue-based reference model.
module tb_pipe_stage;

    localparam int unsigned W   = 32;
    localparam logic [W-1:0] NOP = 32'hDEAD_BEEF;

    logic          CLK;
    logic          RST;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;

    int unsigned   chk_cnt  = 0;
    int unsigned   pass_cnt = 0;

    // Reference model: FIFO of at most two beats plus event counters.
    logic [W-1:0]  mq[$];
    logic [31:0]   m_stall = 32'd0;
    logic [31:0]   m_flush = 32'd0;

    pipe_stage #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // Free-running clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_stall();
`ifdef PIPE_STAGE_STATS_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush();
`ifdef PIPE_STAGE_STATS_EN
        return m_flush;
`else
        return 32'd0;
`endif
    endfunction

    task automatic compare_all();
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
        check_eq("out_data",  out_data, (mq.size() > 0) ? mq[0] : NOP);
        check_eq("in_ready",  {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
        check_eq("occupancy", {30'd0, occupancy}, mq.size());
        check_eq("stall_cnt", stall_cnt, exp_stall());
        check_eq("flush_cnt", flush_cnt, exp_flush());
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [W-1:0] id, input logic ordy);
        bit acc;
        bit con;
        RST       = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        acc = iv && (mq.size() < 2);
        con = (mq.size() > 0) && ordy;
        @(posedge CLK);
        if (rst) begin
            mq.delete();
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else begin
            if ((mq.size() > 0) && !ordy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
            if (fl && (mq.size() > 0) && (m_flush != 32'hFFFF_FFFF)) m_flush++;
            if (fl) begin
                mq.delete();
            end else begin
                if (con) void'(mq.pop_front());
                if (acc) mq.push_back(id);
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        bit            ir;
        logic [W-1:0]  rd;
        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("rst_out_data", out_data, NOP);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming 1,2,3 with out_ready held high
        step(1'b0, 1'b0, 1'b1, 32'd1, 1'b1);
        check_eq("stream_d1", out_data, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'd2, 1'b1);
        check_eq("stream_d2", out_data, 32'd2);
        check_eq("stream_occ", {30'd0, occupancy}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'd3, 1'b1);
        check_eq("stream_d3", out_data, 32'd3);
        check_eq("stream_rdy", {31'd0, in_ready}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("stream_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: 0xA then 0xB with out_ready low
        step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        check_eq("bp_occ2", {30'd0, occupancy}, 32'd2);
        check_eq("bp_rdy0", {31'd0, in_ready}, 32'd0);
        check_eq("bp_head", out_data, 32'hA);
        step(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        check_eq("bp_next", out_data, 32'hB);
        check_eq("bp_rdy1", {31'd0, in_ready}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("bp_empty", {31'd0, out_valid}, 32'd0);
        check_eq("bp_nop", out_data, NOP);

        // Flush colliding with an input beat while FULL
        step(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h6, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h7, 1'b0);
        check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
        check_eq("fl_data", out_data, NOP);
        check_eq("fl_occ", {30'd0, occupancy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            check_eq("fl_no7", {31'd0, out_valid}, 32'd0);
        end

        // Reset (together with flush) while FULL
        step(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h23, 1'b1);
        check_eq("rst_full_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_full_rdy", {31'd0, in_ready}, 32'd1);
        check_eq("rst_full_stall", stall_cnt, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("rst_no_pulse", {31'd0, out_valid}, 32'd0);

        // Statistics: five stall cycles then one flush
        step(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
`ifdef PIPE_STAGE_STATS_EN
        check_eq("stats_stall", stall_cnt, 32'd5);
        check_eq("stats_flush", flush_cnt, 32'd1);
`else
        check_eq("stats_stall_off", stall_cnt, 32'd0);
        check_eq("stats_flush_off", flush_cnt, 32'd0);
`endif

        // Random traffic; also probe in_ready for combinational dependence
        for (int c = 0; c < 10000; c++) begin
            ir = in_ready;
            out_ready = ~out_ready;
            in_valid  = ~in_valid;
            #1;
            check_eq("in_ready_comb", {31'd0, in_ready}, {31'd0, ir});
            rd = $urandom;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 1), rd, ($urandom_range(0, 9) < 6));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
